// File: rtl/tdm_demux4.sv
// tdm_demux4: receive-side 1-to-4 TDM demultiplexer.
// A 2-bit slot counter, aligned by frame_sync, steers each valid sample
// into one of four holding registers. The block also produces per-channel
// strobes, a frame-complete pulse and a framing-error pulse.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       ch_vld,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked,
  output logic             s1,
  output logic             s0
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [1:0]       slot_reg, slot_next;
  logic [3:0]       wr_next;
  logic [3:0]       vld_reg;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] ch_reg [4];

  // Next-state decode. Nothing moves unless a valid sample is present,
  // so gaps of any length leave the slot position and state untouched.
  // Reaching slot 3 while LOCKED implies slots 0..2 were written in order
  // since the last slot-0 write: any break in sequence either resets the
  // slot to 1 (early sync) or drops to HUNT (missing sync).
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    wr_next    = 4'b0000;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (din_valid) begin
      if (state_reg == ST_HUNT) begin
        if (frame_sync) begin
          wr_next    = 4'b0001;
          slot_next  = 2'd1;
          state_next = ST_LOCKED;
        end
      end else begin
        if (frame_sync) begin
          // A sync marker always restarts the frame; arriving mid-frame
          // truncates the previous frame and is reported as an error.
          err_next  = (slot_reg != 2'd0);
          wr_next   = 4'b0001;
          slot_next = 2'd1;
        end else if (slot_reg != 2'd0) begin
          wr_next   = 4'b0001 << slot_reg;
          done_next = (slot_reg == 2'd3);
          slot_next = slot_reg + 2'd1;
        end else begin
          // Expected a sync marker at slot 0 but did not get one.
          err_next   = 1'b1;
          state_next = ST_HUNT;
        end
      end
    end
  end

  // Control state, slot counter and single-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_HUNT;
      slot_reg  <= 2'd0;
      vld_reg   <= 4'b0000;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      vld_reg   <= wr_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // One holding register per channel, loaded only on its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    // Holds its last sample until its slot is written again.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ch_reg[gi] <= '0;
      end else if (wr_next[gi]) begin
        ch_reg[gi] <= din;
      end
    end
  end

  assign a          = ch_reg[0];
  assign b          = ch_reg[1];
  assign c          = ch_reg[2];
  assign d          = ch_reg[3];
  assign ch_vld     = vld_reg;
  assign frame_done = done_reg;
  assign sync_err   = err_reg;
  assign locked     = (state_reg == ST_LOCKED);
  assign s1         = slot_reg[1];
  assign s0         = slot_reg[0];

endmodule
